// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : draw_arbiter
//  Purpose  : Shares one frame buffer write port among three drawing engines
//             (fill, symbol, line). Start requests are queued as one pending
//             bit per client. An idle arbiter grants one client, pulses that
//             drawer's start, waits one settle cycle and then waits for the
//             drawer to report ready. During a grant only the granted drawer's
//             write port reaches the frame buffer, delayed by one register.
//  Ports    : clk, rst                - clock, synchronous active-high reset
//             req_start / req_ready   - per-client start pulse / accept flag
//             frame_lock              - holds off new grants while high
//             drawer_start / _ready   - handshake with the three drawers
//             drawer_write_*          - per-drawer write ports (packed x3)
//             write_enable/addr/data  - registered frame buffer write port
//             busy, overflow          - grant active / sticky dropped start
//  Config   : define DRAW_ARBITER_ROUND_ROBIN_EN for round-robin grants;
//             otherwise fixed priority fill > symbol > line.
//  Revision : 1.0 - initial release
// ============================================================================
module draw_arbiter #(
    parameter int ADDR_WIDTH = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              req_start,
    output logic [2:0]              req_ready,
    input  logic                    frame_lock,
    output logic [2:0]              drawer_start,
    input  logic [2:0]              drawer_ready,
    input  logic [2:0]              drawer_write_enable,
    input  logic [3*ADDR_WIDTH-1:0] drawer_write_addr,
    input  logic [2:0]              drawer_write_data,
    output logic                    write_enable,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic                    write_data,
    output logic                    busy,
    output logic                    overflow
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LAUNCH = 2'd1;
    localparam logic [1:0] c_SETTLE = 2'd2;
    localparam logic [1:0] c_RUN    = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [1:0]            r_grant;
    logic [1:0]            w_sel;
    logic [2:0]            r_pending;
    logic [2:0]            w_accept;
    logic [2:0]            w_sel_onehot;
    logic                  w_launch;
    logic                  w_active;
    logic                  r_overflow;
    logic                  w_mux_we;
    logic                  w_mux_wd;
    logic [ADDR_WIDTH-1:0] w_mux_wa;
    logic                  r_write_enable;
    logic                  r_write_data;
    logic [ADDR_WIDTH-1:0] r_write_addr;

    assign w_active = (r_state != c_IDLE);
    // Selection only looks at already-registered pending bits, so a start
    // arriving in the decision cycle waits for the next idle cycle.
    assign w_launch = (r_state == c_IDLE) && !frame_lock && (r_pending != 3'b000);

    // The granted client stays not-ready for the whole grant so that a new
    // start from it cannot be queued behind its own running job.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ready
            assign req_ready[gi] = ~r_pending[gi] & ~(w_active & (r_grant == 2'(gi)));
        end
    endgenerate

    assign w_accept     = req_start & req_ready;
    assign w_sel_onehot = 3'b001 << w_sel;

`ifdef DRAW_ARBITER_ROUND_ROBIN_EN
    logic [1:0] r_rr_ptr;
    logic [1:0] w_rr_first;
    logic [1:0] w_rr_second;
    logic [1:0] w_rr_third;

    function automatic logic [1:0] f_next(input logic [1:0] cur);
        return (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    endfunction

    // Search order starts just after the most recent grant.
    assign w_rr_first  = f_next(r_rr_ptr);
    assign w_rr_second = f_next(w_rr_first);
    assign w_rr_third  = f_next(w_rr_second);

    always_comb begin
        w_sel = w_rr_third;
        if (r_pending[w_rr_first]) begin
            w_sel = w_rr_first;
        end else if (r_pending[w_rr_second]) begin
            w_sel = w_rr_second;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 2'd0;
        end else if (w_launch) begin
            r_rr_ptr <= w_sel;
        end
    end
`else
    always_comb begin
        w_sel = 2'd2;
        if (r_pending[0]) begin
            w_sel = 2'd0;
        end else if (r_pending[1]) begin
            w_sel = 2'd1;
        end
    end
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (w_launch) w_next_state = c_LAUNCH;
            c_LAUNCH: w_next_state = c_SETTLE;
            // Drawer ready may still be stale here, so it is not looked at.
            c_SETTLE: w_next_state = c_RUN;
            c_RUN:    if (drawer_ready[r_grant]) w_next_state = c_IDLE;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy         = w_active;
        drawer_start = 3'b000;
        if (r_state == c_LAUNCH) begin
            drawer_start = 3'b001 << r_grant;
        end
    end

    // Grant, pending queue and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant    <= 2'd0;
            r_pending  <= 3'b000;
            r_overflow <= 1'b0;
        end else begin
            if (w_launch) begin
                r_grant <= w_sel;
            end
            r_pending <= (r_pending | w_accept) & ~(w_launch ? w_sel_onehot : 3'b000);
            if ((req_start & ~req_ready) != 3'b000) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Write port mux; the granted lane only.
    always_comb begin
        case (r_grant)
            2'd1: begin
                w_mux_we = drawer_write_enable[1];
                w_mux_wa = drawer_write_addr[ADDR_WIDTH +: ADDR_WIDTH];
                w_mux_wd = drawer_write_data[1];
            end
            2'd2: begin
                w_mux_we = drawer_write_enable[2];
                w_mux_wa = drawer_write_addr[2*ADDR_WIDTH +: ADDR_WIDTH];
                w_mux_wd = drawer_write_data[2];
            end
            default: begin
                w_mux_we = drawer_write_enable[0];
                w_mux_wa = drawer_write_addr[0 +: ADDR_WIDTH];
                w_mux_wd = drawer_write_data[0];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !w_active) begin
            r_write_enable <= 1'b0;
            r_write_addr   <= '0;
            r_write_data   <= 1'b0;
        end else begin
            r_write_enable <= w_mux_we;
            r_write_addr   <= w_mux_wa;
            r_write_data   <= w_mux_wd;
        end
    end

    assign write_enable = r_write_enable;
    assign write_addr   = r_write_addr;
    assign write_data   = r_write_data;
    assign overflow     = r_overflow;

endmodule

`default_nettype wire
